// File: rtl/mem_pipe_pkg.sv
// Shared types and sizes for the EX/MEM pipeline register and its controller.
package mem_pipe_pkg;

    localparam int unsigned DATA_W      = 16;
    localparam int unsigned REG_W       = 3;
    localparam int unsigned TIMEOUT_DEF = 16;

    typedef enum logic {
        RUN  = 1'b0,
        WAIT = 1'b1
    } state_t;

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] wdata;
        logic              rd_en;
        logic              wr_en;
        logic              halt;
        logic              reg_wr;
        logic [REG_W-1:0]  wr_reg;
        logic              mem_to_reg;
    } ex_mem_t;

    // A bubble clears every control bit but keeps the datapath values steady.
    function automatic ex_mem_t bubble_of(input ex_mem_t prev);
        ex_mem_t b;
        b       = '0;
        b.alu   = prev.alu;
        b.wdata = prev.wdata;
        return b;
    endfunction

endpackage

// File: rtl/ex_mem_ctrl.sv
// Load/hold control for the EX/MEM register: RUN/WAIT FSM, wait timeout,
// deferred flush, sticky halt and the upstream stall.
module ex_mem_ctrl
    import mem_pipe_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic access,
    input  logic halt_present,
    input  logic ex_valid,
    input  logic flush,
    input  logic mem_stall,
    input  logic mem_done,
    output logic load,
    output logic bubble,
    output logic stall_up,
    output logic halted,
    output logic err
);

    localparam int unsigned     CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
    // Counter holds (WAIT cycle number - 1), so this value means the
    // TIMEOUT-th WAIT cycle is the one about to start.
    localparam logic [CNT_W-1:0] ERR_AT  = CNT_W'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             flush_pend_q, flush_pend_d;
    logic             halted_q, halted_d;
    logic             err_q, err_d;
    logic             advance;

    always_comb begin
        state_d = state_q;
        advance = 1'b0;
        unique case (state_q)
            RUN: begin
                if (access && mem_stall && !mem_done) begin
                    state_d = WAIT;
                end else begin
                    advance = 1'b1;
                end
            end
            WAIT: begin
                if (mem_done) begin
                    state_d = RUN;
                    advance = 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == RUN && state_d == WAIT) begin
            cnt_d = '0;
        end else if (state_q == WAIT && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Halt blocks the register only; the FSM keeps tracking the memory.
    assign load     = advance & ~halted_q;
    assign stall_up = ~load;
    assign bubble   = flush | flush_pend_q | ~ex_valid;

    always_comb begin
        flush_pend_d = flush_pend_q;
        if (load) begin
            flush_pend_d = 1'b0;
        end else if (flush) begin
            flush_pend_d = 1'b1;
        end
    end

    assign halted_d = halted_q | (load & halt_present);
    assign err_d    = err_q | ((state_d == WAIT) && (cnt_d >= ERR_AT));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= RUN;
            cnt_q        <= '0;
            flush_pend_q <= 1'b0;
            halted_q     <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            flush_pend_q <= flush_pend_d;
            halted_q     <= halted_d;
            err_q        <= err_d;
        end
    end

    assign halted = halted_q;
    assign err    = err_q;

endmodule

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register bank; holds while the data memory is busy and
// captures bubbles on flush or invalid execute results.
module ex_mem_reg
    import mem_pipe_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic [DATA_W-1:0] ex_alu,
    input  logic [DATA_W-1:0] ex_wdata,
    input  logic              ex_rd_en,
    input  logic              ex_wr_en,
    input  logic              ex_halt,
    input  logic              ex_reg_wr,
    input  logic [REG_W-1:0]  ex_wr_reg,
    input  logic              ex_mem_to_reg,
    input  logic              flush,
    input  logic              mem_stall,
    input  logic              mem_done,
    output logic              mem_valid,
    output logic [DATA_W-1:0] mem_alu,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rd_en,
    output logic              mem_wr_en,
    output logic              mem_halt,
    output logic              mem_reg_wr,
    output logic [REG_W-1:0]  mem_wr_reg,
    output logic              mem_mem_to_reg,
    output logic              stall_up,
    output logic              halted,
    output logic              err
);

    ex_mem_t entry_q, entry_d, ex_entry;
    logic    load, bubble, access, halt_present;

    assign access       = entry_q.valid & (entry_q.rd_en | entry_q.wr_en);
    assign halt_present = entry_q.valid & entry_q.halt;

    ex_mem_ctrl #(
        .TIMEOUT(TIMEOUT)
    ) u_ctrl (
        .clk         (clk),
        .rst         (rst),
        .access      (access),
        .halt_present(halt_present),
        .ex_valid    (ex_valid),
        .flush       (flush),
        .mem_stall   (mem_stall),
        .mem_done    (mem_done),
        .load        (load),
        .bubble      (bubble),
        .stall_up    (stall_up),
        .halted      (halted),
        .err         (err)
    );

    always_comb begin
        ex_entry            = '0;
        ex_entry.valid      = 1'b1;
        ex_entry.alu        = ex_alu;
        ex_entry.wdata      = ex_wdata;
        ex_entry.rd_en      = ex_rd_en;
        ex_entry.wr_en      = ex_wr_en;
        ex_entry.halt       = ex_halt;
        ex_entry.reg_wr     = ex_reg_wr;
        ex_entry.wr_reg     = ex_wr_reg;
        ex_entry.mem_to_reg = ex_mem_to_reg;
        entry_d = bubble ? bubble_of(entry_q) : ex_entry;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            entry_q <= '0;
        end else if (load) begin
            entry_q <= entry_d;
        end
    end

    assign mem_valid      = entry_q.valid;
    assign mem_alu        = entry_q.alu;
    assign mem_wdata      = entry_q.wdata;
    assign mem_rd_en      = entry_q.rd_en;
    assign mem_wr_en      = entry_q.wr_en;
    assign mem_halt       = entry_q.halt;
    assign mem_reg_wr     = entry_q.reg_wr;
    assign mem_wr_reg     = entry_q.wr_reg;
    assign mem_mem_to_reg = entry_q.mem_to_reg;

endmodule

// File: tb/tb_ex_mem_reg.sv
// Randomized scoreboard bench for ex_mem_reg with a behavioural pipeline model
// plus directed scenarios for stalls, flushes, halt, timeout and async reset.
module tb_ex_mem_reg;

    localparam int unsigned TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ex_valid, ex_rd_en, ex_wr_en, ex_halt, ex_reg_wr, ex_mem_to_reg;
    logic [15:0] ex_alu, ex_wdata;
    logic [2:0]  ex_wr_reg;
    logic        flush, mem_stall, mem_done;
    logic        mem_valid, mem_rd_en, mem_wr_en, mem_halt, mem_reg_wr, mem_mem_to_reg;
    logic [15:0] mem_alu, mem_wdata;
    logic [2:0]  mem_wr_reg;
    logic        stall_up, halted, err;

    always #5 clk = ~clk;

    ex_mem_reg #(
        .TIMEOUT(TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ex_valid      (ex_valid),
        .ex_alu        (ex_alu),
        .ex_wdata      (ex_wdata),
        .ex_rd_en      (ex_rd_en),
        .ex_wr_en      (ex_wr_en),
        .ex_halt       (ex_halt),
        .ex_reg_wr     (ex_reg_wr),
        .ex_wr_reg     (ex_wr_reg),
        .ex_mem_to_reg (ex_mem_to_reg),
        .flush         (flush),
        .mem_stall     (mem_stall),
        .mem_done      (mem_done),
        .mem_valid     (mem_valid),
        .mem_alu       (mem_alu),
        .mem_wdata     (mem_wdata),
        .mem_rd_en     (mem_rd_en),
        .mem_wr_en     (mem_wr_en),
        .mem_halt      (mem_halt),
        .mem_reg_wr    (mem_reg_wr),
        .mem_wr_reg    (mem_wr_reg),
        .mem_mem_to_reg(mem_mem_to_reg),
        .stall_up      (stall_up),
        .halted        (halted),
        .err           (err)
    );

    typedef struct packed {
        logic        valid;
        logic [15:0] alu;
        logic [15:0] wdata;
        logic        rd_en;
        logic        wr_en;
        logic        halt;
        logic        reg_wr;
        logic [2:0]  wr_reg;
        logic        m2r;
        logic        flush;
        logic        stall;
        logic        done;
    } stim_t;

    typedef struct packed {
        logic        valid;
        logic [15:0] alu;
        logic [15:0] wdata;
        logic        rd_en;
        logic        wr_en;
        logic        halt;
        logic        reg_wr;
        logic [2:0]  wr_reg;
        logic        m2r;
    } ent_t;

    typedef struct packed {
        ent_t e;
        logic stall_up;
        logic halted;
        logic err;
    } exp_t;

    exp_t sbq[$];

    // Reference model: what the memory stage currently holds, whether an access
    // is outstanding, which WAIT cycle we are in, and the sticky flags.
    ent_t m;
    bit   m_waiting, m_fp, m_halted, m_err;
    int   m_wcyc;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    task automatic model_reset();
        m = '0;
        m_waiting = 0;
        m_fp = 0;
        m_halted = 0;
        m_err = 0;
        m_wcyc = 0;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic drive(input stim_t s);
        ex_valid = s.valid;
        ex_alu = s.alu;
        ex_wdata = s.wdata;
        ex_rd_en = s.rd_en;
        ex_wr_en = s.wr_en;
        ex_halt = s.halt;
        ex_reg_wr = s.reg_wr;
        ex_wr_reg = s.wr_reg;
        ex_mem_to_reg = s.m2r;
        flush = s.flush;
        mem_stall = s.stall;
        mem_done = s.done;
    endtask

    // One clock of stimulus: predict this cycle's outputs, then advance the model.
    task automatic cycle(input stim_t s);
        exp_t x;
        bit   pending, moves;
        drive(s);
        pending = m.valid && (m.rd_en || m.wr_en);
        if (m_waiting) moves = s.done;
        else moves = !(pending && s.stall && !s.done);
        if (m_halted) moves = 0;
        x.e = m;
        x.stall_up = !moves;
        x.halted = m_halted;
        x.err = m_err;
        sbq.push_back(x);

        if (m_waiting) begin
            if (s.done) m_waiting = 0;
            else m_wcyc++;
        end else if (pending && s.stall && !s.done) begin
            m_waiting = 1;
            m_wcyc = 1;
        end
        if (m_waiting && m_wcyc >= TO) m_err = 1;

        if (moves) begin
            if (m.valid && m.halt) m_halted = 1;
            if (s.flush || m_fp || !s.valid) begin
                m.valid = 0;
                m.rd_en = 0;
                m.wr_en = 0;
                m.halt = 0;
                m.reg_wr = 0;
                m.m2r = 0;
            end else begin
                m.valid = 1;
                m.alu = s.alu;
                m.wdata = s.wdata;
                m.rd_en = s.rd_en;
                m.wr_en = s.wr_en;
                m.halt = s.halt;
                m.reg_wr = s.reg_wr;
                m.wr_reg = s.wr_reg;
                m.m2r = s.m2r;
            end
            m_fp = 0;
        end else if (s.flush) begin
            m_fp = 1;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        drive('0);
        rst = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
    endtask

    function automatic stim_t mk(input logic [15:0] alu, input logic rd, input logic wr,
                                 input logic stall, input logic done, input logic fl);
        stim_t s;
        s = '0;
        s.valid = 1'b1;
        s.alu = alu;
        s.wdata = ~alu;
        s.rd_en = rd;
        s.wr_en = wr;
        s.stall = stall;
        s.done = done;
        s.flush = fl;
        return s;
    endfunction

    function automatic stim_t rnd_stim();
        stim_t s;
        s.valid = ($urandom_range(0, 9) != 0);
        s.alu = 16'($urandom);
        s.wdata = 16'($urandom);
        s.rd_en = ($urandom_range(0, 9) < 3);
        s.wr_en = ($urandom_range(0, 9) < 2);
        s.halt = 1'b0;
        s.reg_wr = 1'($urandom);
        s.wr_reg = 3'($urandom);
        s.m2r = 1'($urandom);
        s.flush = ($urandom_range(0, 9) == 0);
        s.stall = 1'($urandom);
        s.done = ($urandom_range(0, 3) == 0);
        return s;
    endfunction

    // Monitor: registered outputs are compared mid-cycle against the queued prediction.
    always @(negedge clk) begin
        exp_t x;
        logic [8:0] ca, ce;
        if (sbq.size() != 0) begin
            x = sbq.pop_front();
            ca = {mem_valid, mem_rd_en, mem_wr_en, mem_halt, mem_reg_wr, mem_mem_to_reg,
                  stall_up, halted, err};
            ce = {x.e.valid, x.e.rd_en, x.e.wr_en, x.e.halt, x.e.reg_wr, x.e.m2r,
                  x.stall_up, x.halted, x.err};
            checks++;
            if (ca !== ce) begin
                failures++;
                $display("FAIL sb_ctrl cyc=%0d actual=%b required=%b", cyc, ca, ce);
            end
            if (x.e.valid) begin
                checks++;
                if ({mem_alu, mem_wdata, mem_wr_reg} !== {x.e.alu, x.e.wdata, x.e.wr_reg}) begin
                    failures++;
                    $display("FAIL sb_data cyc=%0d actual=%h/%h/%0d required=%h/%h/%0d", cyc,
                             mem_alu, mem_wdata, mem_wr_reg, x.e.alu, x.e.wdata, x.e.wr_reg);
                end
            end
        end
    end

    initial begin
        stim_t s;
        drive('0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", 64'({mem_valid, mem_alu, mem_wdata, mem_rd_en, mem_wr_en,
              mem_halt, mem_reg_wr, mem_wr_reg, mem_mem_to_reg, stall_up, halted, err}), 64'd0);
        rst = 1'b1;

        // Plain load, no memory access.
        s = mk(16'h1234, 0, 0, 0, 0, 0);
        s.reg_wr = 1'b1;
        s.wr_reg = 3'd5;
        cycle(s);
        check("load_alu", 64'(mem_alu), 64'h1234);
        check("load_wr_reg", 64'(mem_wr_reg), 64'd5);
        check("load_valid", 64'(mem_valid), 64'd1);

        // Read held for three stall cycles, released by done.
        cycle(mk(16'h0040, 1, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++) begin
            cycle(mk(16'hbeef, 0, 0, 1, 0, 0));
            check("hold_alu", 64'(mem_alu), 64'h0040);
            check("hold_rd_en", 64'(mem_rd_en), 64'd1);
        end
        cycle(mk(16'hbeef, 0, 0, 0, 1, 0));
        check("done_load_alu", 64'(mem_alu), 64'hbeef);
        check("done_load_rd_en", 64'(mem_rd_en), 64'd0);

        // Flush during WAIT is deferred to the next load.
        cycle(mk(16'h0100, 1, 0, 0, 0, 0));
        cycle(mk(16'h0111, 0, 0, 1, 0, 0));
        cycle(mk(16'h0122, 0, 0, 1, 0, 1));
        cycle(mk(16'h0133, 0, 0, 1, 0, 0));
        cycle(mk(16'h0200, 0, 0, 0, 1, 0));
        check("flush_pend_bubble", 64'(mem_valid), 64'd0);
        cycle(mk(16'h0300, 0, 0, 0, 0, 0));
        check("flush_pend_cleared", 64'({mem_valid, mem_alu}), 64'h1_0300);

        // Done together with flush completes the access and loads a bubble.
        cycle(mk(16'h0400, 0, 1, 0, 0, 0));
        cycle(mk(16'h0411, 0, 0, 1, 0, 0));
        cycle(mk(16'h0500, 0, 0, 0, 1, 1));
        check("done_flush_bubble", 64'({mem_valid, mem_wr_en}), 64'd0);

        for (int i = 0; i < 400; i++) cycle(rnd_stim());

        // Timeout: err rises as the TIMEOUT-th WAIT cycle starts; FSM keeps waiting.
        do_reset();
        cycle(mk(16'h0600, 1, 0, 0, 0, 0));
        for (int k = 1; k <= 20; k++) begin
            cycle(mk(16'h0700, 0, 0, 1, 0, 0));
            if (k == TO - 1) check("err_before_timeout", 64'(err), 64'd0);
            if (k == TO) check("err_at_timeout", 64'(err), 64'd1);
        end
        check("still_waiting", 64'({mem_rd_en, mem_alu}), 64'h1_0600);
        #2;
        rst = 1'b0;
        #1;
        check("async_reset", 64'({mem_valid, mem_alu, mem_wdata, mem_rd_en, mem_wr_en, mem_halt,
              mem_reg_wr, mem_wr_reg, mem_mem_to_reg, stall_up, halted, err}), 64'd0);
        drive('0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();

        // Halt: sticky once the halt instruction moves on; further loads blocked.
        s = mk(16'h0800, 0, 0, 0, 0, 0);
        s.halt = 1'b1;
        cycle(s);
        check("halt_loaded", 64'({mem_halt, halted}), 64'b10);
        cycle(mk(16'h0900, 0, 0, 0, 0, 0));
        check("halted_set", 64'(halted), 64'd1);
        for (int i = 0; i < 6; i++) cycle(rnd_stim());
        check("halted_blocks", 64'({halted, mem_alu}), 64'h1_0900);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ex_mem_reg.md
EX_MEM_REG -- requirements
Module: ex_mem_reg

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16: WAIT-state cycles before err is raised.
REQ-002 SHALL have port clk  in  1  the single processor clock; all state on the rising edge.
REQ-003 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports ex_valid in 1, ex_alu in 16, ex_wdata in 16, ex_rd_en in 1, ex_wr_en in 1, ex_halt in 1, ex_reg_wr in 1, ex_wr_reg in 3, ex_mem_to_reg in 1: the execute-stage result and controls.
REQ-005 SHALL have port flush  in  1  squashes the instruction being loaded this cycle.
REQ-006 SHALL have ports mem_stall in 1 and mem_done in 1: Stall and Done from the data memory.
REQ-007 SHALL have outputs mem_valid 1, mem_alu 16, mem_wdata 16, mem_rd_en 1, mem_wr_en 1, mem_halt 1, mem_reg_wr 1, mem_wr_reg 3, mem_mem_to_reg 1: the registered copy driving the memory stage.
REQ-008 SHALL have outputs stall_up 1 (freeze upstream stages), halted 1 (sticky) and err 1 (sticky timeout).

Function
REQ-009 SHALL implement FSM states RUN and WAIT.
REQ-010 An access SHALL be defined as mem_valid & (mem_rd_en | mem_wr_en).
REQ-011 In RUN with no access, or with an access and mem_done=1, the register SHALL load the EX inputs at the next edge (1-cycle latency).
REQ-012 In RUN with an access, mem_stall=1 and mem_done=0, the register SHALL hold and the FSM SHALL go to WAIT.
REQ-013 In WAIT the register SHALL hold, and mem_rd_en/mem_wr_en SHALL stay asserted; mem_done=1 SHALL return the FSM to RUN and permit the load at that same edge.
REQ-014 In RUN with an access, mem_stall=0 and mem_done=0, the register SHALL load (single-cycle memory hit).
REQ-015 stall_up SHALL be combinational: 1 whenever the register holds this cycle (REQ-012/013) or halted=1; otherwise 0.
REQ-016 On a load with flush=1 or ex_valid=0, the register SHALL capture a bubble: mem_valid and all control outputs 0; data outputs don't-care and held at the previous value.
REQ-017 flush asserted while the register holds SHALL set flush_pend; the next load SHALL be a bubble and clear flush_pend.
REQ-018 A load with mem_valid=1 and mem_halt=1 already present SHALL set halted; while halted=1, further loads SHALL be blocked until reset.
REQ-019 A saturating wait counter SHALL clear on entry to WAIT and increment each WAIT cycle; reaching TIMEOUT SHALL set err.
REQ-020 err SHALL not alter the FSM; the FSM SHALL still exit WAIT on mem_done.
REQ-021 mem_done=1 in the same cycle as flush=1 SHALL complete the access and load a bubble.

Reset
REQ-022 rst=0 SHALL asynchronously force: FSM to RUN; all outputs 0 (including mem_valid, halted, err); flush_pend 0; counter 0.
REQ-023 Reset during WAIT SHALL abandon the outstanding access with no retry.
REQ-024 Normal operation SHALL resume on the first clk edge after rst returns to 1.

Structure
REQ-025 Shared package mem_pipe_pkg SHALL hold: the state typedef (RUN, WAIT), DATA_W=16, REG_W=3, and the TIMEOUT default.
REQ-026 One sub-module, ex_mem_ctrl, SHALL contain the FSM, wait counter, flush_pend, halted, err and stall_up; the top holds only the data/control register bank.

Verification
REQ-027 Load with ex_alu=0x1234, ex_reg_wr=1, ex_wr_reg=5, no access -> next cycle mem_alu=0x1234, mem_wr_reg=5, mem_valid=1, stall_up=0.
REQ-028 Load with ex_rd_en=1, ex_alu=0x0040; mem_stall=1 for 3 cycles then mem_done=1 -> stall_up=1 for 3 cycles, mem_rd_en and mem_alu=0x0040 held throughout, new instruction loaded at the done edge.
REQ-029 flush=1 pulsed mid-WAIT, mem_done 2 cycles later -> the next loaded entry has mem_valid=0 and flush_pend is cleared.
REQ-030 Load with ex_halt=1, ex_valid=1 -> halted=1 one cycle later, stall_up stays 1, and later ex_valid inputs are ignored.
REQ-031 Hold mem_stall=1 with no mem_done for 20 cycles -> err=1 on WAIT cycle 16, FSM still WAIT; then assert rst=0 -> all outputs 0 immediately, without waiting for a clk edge.
